// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller: MIPS opcode and
// funct constants, forwarding-select codes, the decoded-instruction record
// produced by ins_decode, and the small register-compare helpers used by
// the top level.
// ---------------------------------------------------------------------------
package hazard_pkg;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes (instruction bits 5:0)
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM rt field selectors we care about
  localparam logic [4:0] RI_BLTZ = 5'h00;
  localparam logic [4:0] RI_BGEZ = 5'h01;

  // Link register written by jal
  localparam logic [4:0] REG_RA = 5'd31;

  // Forwarding mux selects
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  // Everything the hazard logic needs to know about one pipeline stage
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rs_use;
    logic       rt_use;
    logic       is_load;
    logic       is_mult;
    logic       is_div;
    logic       is_md;
    logic       is_hilo;
    logic       is_br;
  } dec_t;

  // $0 is hard-wired, so a read of it never depends on any producer
  function automatic logic src_match(input logic [4:0] src,
                                     input logic       use_bit,
                                     input logic [4:0] dst);
    return (src != 5'd0) && use_bit && (src == dst);
  endfunction

  // A load in M has no data yet, so only a non-load M result may be bypassed;
  // M is checked first because it holds the younger value
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       use_bit,
                                         input logic [4:0] m_dst,
                                         input logic       m_is_load,
                                         input logic [4:0] w_dst);
    if (src_match(src, use_bit, m_dst) && !m_is_load) begin
      return FWD_M;
    end else if (src_match(src, use_bit, w_dst)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ins_decode.sv
// ---------------------------------------------------------------------------
// ins_decode
// Turns one 32-bit MIPS instruction word into the hazard-relevant summary:
// which source registers are read, which register is written, and the
// load / mult-div / HI-LO / branch classification.
//
// Ports
//   ins_i  in  32   instruction word (all-zero word is a bubble)
//   dec_o  out dec_t  decoded summary
// ---------------------------------------------------------------------------
module ins_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ins_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = ins_i[31:26];
  assign rs    = ins_i[25:21];
  assign rt    = ins_i[20:16];
  assign rd    = ins_i[15:11];
  assign funct = ins_i[5:0];

  // Classify the word. The all-zero word is architecturally sll $0,$0,0 but is
  // treated as a pure bubble so it never reads or writes anything.
  always_comb begin
    dec_o    = '0;
    dec_o.rs = rs;
    dec_o.rt = rt;
    if (ins_i != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA: begin
              // shift amount comes from the immediate field, only rt is read
              dec_o.rt_use = 1'b1;
              dec_o.dst    = rd;
            end
            FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: begin
              dec_o.rs_use = 1'b1;
              dec_o.rt_use = 1'b1;
              dec_o.dst    = rd;
            end
            FN_JR: begin
              dec_o.rs_use = 1'b1;
              dec_o.is_br  = 1'b1;
            end
            FN_JALR: begin
              dec_o.rs_use = 1'b1;
              dec_o.dst    = rd;
              dec_o.is_br  = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
              dec_o.dst     = rd;
              dec_o.is_hilo = 1'b1;
            end
            FN_MTHI, FN_MTLO: begin
              dec_o.rs_use  = 1'b1;
              dec_o.is_hilo = 1'b1;
            end
            FN_MULT, FN_MULTU: begin
              dec_o.rs_use  = 1'b1;
              dec_o.rt_use  = 1'b1;
              dec_o.is_mult = 1'b1;
              dec_o.is_md   = 1'b1;
              dec_o.is_hilo = 1'b1;
            end
            FN_DIV, FN_DIVU: begin
              dec_o.rs_use  = 1'b1;
              dec_o.rt_use  = 1'b1;
              dec_o.is_div  = 1'b1;
              dec_o.is_md   = 1'b1;
              dec_o.is_hilo = 1'b1;
            end
            default: ;
          endcase
        end
        OP_REGIMM: begin
          if ((rt == RI_BLTZ) || (rt == RI_BGEZ)) begin
            dec_o.rs_use = 1'b1;
            dec_o.is_br  = 1'b1;
          end
        end
        OP_JAL: begin
          dec_o.dst = REG_RA;
        end
        OP_BEQ, OP_BNE: begin
          dec_o.rs_use = 1'b1;
          dec_o.rt_use = 1'b1;
          dec_o.is_br  = 1'b1;
        end
        OP_BLEZ, OP_BGTZ: begin
          dec_o.rs_use = 1'b1;
          dec_o.is_br  = 1'b1;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI: begin
          dec_o.rs_use = 1'b1;
          dec_o.dst    = rt;
        end
        OP_LUI: begin
          dec_o.dst = rt;
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          dec_o.rs_use  = 1'b1;
          dec_o.dst     = rt;
          dec_o.is_load = 1'b1;
        end
        OP_SB, OP_SH, OP_SW: begin
          // stores read the base (rs) and the data (rt) but write no register
          dec_o.rs_use = 1'b1;
          dec_o.rt_use = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the five-stage MIPS pipeline. Decodes the D/E/M/W
// instruction words, picks bypass sources for the D-stage compare operands
// and the E-stage ALU operands, and raises a single stall for load-use,
// branch-dependency and HI/LO-busy hazards. Tracks outstanding mult/div
// latency and counts stalled cycles.
//
// Parameters
//   MULT_LAT  cycles HI/LO stays busy after mult/multu leaves E (>= 1)
//   DIV_LAT   cycles HI/LO stays busy after div/divu leaves E (>= 1)
//   CNT_W     width of the saturating stall-cycle counter
//
// Ports
//   clk                      in   rising-edge clock
//   reset                    in   asynchronous, active-high
//   ins_D/E/M/W              in   32-bit instruction word per stage, 0 = bubble
//   ForwardAD, ForwardBD     out  D-stage rs/rt source (0 RF, 1 M, 2 W)
//   ForwardAE, ForwardBE     out  E-stage rs/rt source (0 RF, 1 M, 2 W)
//   stall                    out  freeze PC and F/D, bubble into E
//   md_busy                  out  HI/LO result still pending
//   stall_cnt                out  stalled cycles since reset, saturating
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins_D,
  input  logic [31:0]      ins_E,
  input  logic [31:0]      ins_M,
  input  logic [31:0]      ins_W,
  output logic [1:0]       ForwardAD,
  output logic [1:0]       ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The busy counter only has to hold the longer of the two latencies
  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  dec_t decD;
  dec_t decE;
  dec_t decM;
  dec_t decW;

  logic [MD_W-1:0]  md_cnt_q;
  logic [MD_W-1:0]  md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic dUsesE;
  logic dUsesM;
  logic loadUse;
  logic branchDep;
  logic hiloWait;

  // Not every stage needs every decoded field; folding them together keeps
  // the unused ones from looking like dangling logic
  logic unused_dec;
  assign unused_dec = ^{decD, decE, decM, decW};

  ins_decode u_dec_d (.ins_i(ins_D), .dec_o(decD));
  ins_decode u_dec_e (.ins_i(ins_E), .dec_o(decE));
  ins_decode u_dec_m (.ins_i(ins_M), .dec_o(decM));
  ins_decode u_dec_w (.ins_i(ins_W), .dec_o(decW));

  // Bypass selects. They are computed even while stalled; the datapath simply
  // ignores them in that case.
  assign ForwardAD = fwd_sel(decD.rs, decD.rs_use, decM.dst, decM.is_load, decW.dst);
  assign ForwardBD = fwd_sel(decD.rt, decD.rt_use, decM.dst, decM.is_load, decW.dst);
  assign ForwardAE = fwd_sel(decE.rs, decE.rs_use, decM.dst, decM.is_load, decW.dst);
  assign ForwardBE = fwd_sel(decE.rt, decE.rt_use, decM.dst, decM.is_load, decW.dst);

  // Stall sources. A branch resolves in D, so it must wait for any producer
  // still in E and for a load still in M; ordinary ALU consumers only have
  // to wait for a load sitting in E. Anything touching HI/LO waits until the
  // mult/div unit is idle, including the cycle the md op itself is in E.
  always_comb begin
    dUsesE    = src_match(decD.rs, decD.rs_use, decE.dst) ||
                src_match(decD.rt, decD.rt_use, decE.dst);
    dUsesM    = src_match(decD.rs, decD.rs_use, decM.dst) ||
                src_match(decD.rt, decD.rt_use, decM.dst);
    loadUse   = decE.is_load && dUsesE;
    branchDep = decD.is_br && (dUsesE || (decM.is_load && dUsesM));
    hiloWait  = decD.is_hilo && (md_busy || decE.is_md);
    stall     = loadUse || branchDep || hiloWait;
  end

  // HI/LO busy counter. A new md op in E always reloads, even if a previous
  // one is still counting down.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (decE.is_mult) begin
      md_cnt_d = MD_W'(MULT_LAT);
    end else if (decE.is_div) begin
      md_cnt_d = MD_W'(DIV_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Self-checking bench for hazard_unit. Two instances share the same inputs:
// one with a 32-bit stall counter and one with a 4-bit counter so saturation
// is reachable. A behavioural model tracks which registers each stage reads
// and writes, when HI/LO becomes free, and how many cycles were stalled.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] insD;
  logic [31:0] insE;
  logic [31:0] insM;
  logic [31:0] insW;

  logic [1:0]  fAD, fBD, fAE, fBE;
  logic        stallOut, busyOut;
  logic [31:0] cntOut;

  logic [1:0]  sAD, sBD, sAE, sBE;
  logic        sStall, sBusy;
  logic [3:0]  sCnt;

  hazard_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ins_D(insD), .ins_E(insE), .ins_M(insM), .ins_W(insW),
    .ForwardAD(fAD), .ForwardBD(fBD), .ForwardAE(fAE), .ForwardBE(fBE),
    .stall(stallOut), .md_busy(busyOut), .stall_cnt(cntOut)
  );

  hazard_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset),
    .ins_D(insD), .ins_E(insE), .ins_M(insM), .ins_W(insW),
    .ForwardAD(sAD), .ForwardBD(sBD), .ForwardAE(sAE), .ForwardBE(sBE),
    .stall(sStall), .md_busy(sBusy), .stall_cnt(sCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What one instruction means to the hazard model: registers read (0 when
  // not read, since $0 never creates a dependency), register written, and
  // how long it occupies HI/LO if it is a mult/div
  typedef struct {
    int srcA;
    int srcB;
    int dst;
    bit ld;
    bit hilo;
    bit br;
    int lat;
  } tbDec_t;

  int nChecks = 0;
  int nFail   = 0;

  // Model state: current cycle number, last cycle during which HI/LO is busy,
  // total stalled cycles since reset
  int cyc        = 0;
  int busyEnd    = -1;
  int stallTotal = 0;
  bit expStall   = 0;
  int expLat     = 0;

  function automatic logic [31:0] rIns(input int rs, input int rt, input int rd,
                                       input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] iIns(input int op, input int rs, input int rt,
                                       input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic tbDec_t refDecode(input logic [31:0] w);
    tbDec_t d;
    int op, rs, rt, rd, fn;
    d  = '{default: 0};
    op = int'(w[31:26]);
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    rd = int'(w[15:11]);
    fn = int'(w[5:0]);
    if (w == 32'h0) return d;
    case (op) inside
      0: begin
        if (fn inside {0, 2, 3}) begin
          d.srcB = rt; d.dst = rd;
        end else if (fn inside {4, 6, 7, [32:39], 42, 43}) begin
          d.srcA = rs; d.srcB = rt; d.dst = rd;
        end else if (fn == 8 || fn == 9) begin
          d.srcA = rs; d.br = 1;
          if (fn == 9) d.dst = rd;
        end else if (fn == 16 || fn == 18) begin
          d.dst = rd; d.hilo = 1;
        end else if (fn == 17 || fn == 19) begin
          d.srcA = rs; d.hilo = 1;
        end else if (fn inside {[24:27]}) begin
          d.srcA = rs; d.srcB = rt; d.hilo = 1;
          d.lat  = (fn < 26) ? MULT_LAT : DIV_LAT;
        end
      end
      1:                  if (rt <= 1) begin d.srcA = rs; d.br = 1; end
      3:                  d.dst = 31;
      4, 5:               begin d.srcA = rs; d.srcB = rt; d.br = 1; end
      6, 7:               begin d.srcA = rs; d.br = 1; end
      [8:14]:             begin d.srcA = rs; d.dst = rt; end
      15:                 d.dst = rt;
      32, 33, 35, 36, 37: begin d.srcA = rs; d.dst = rt; d.ld = 1; end
      40, 41, 43:         begin d.srcA = rs; d.srcB = rt; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic bit hit(input int src, input int dst);
    return (src != 0) && (src == dst);
  endfunction

  function automatic logic [1:0] refFwd(input int src, input tbDec_t m, input tbDec_t w);
    if (hit(src, m.dst) && !m.ld) return 2'd1;
    if (hit(src, w.dst))          return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] randIns();
    int a, b, c;
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    case ($urandom_range(0, 13))
      0:  return 32'h0;
      1:  return rIns(a, b, c, 0, 'h21);
      2:  return rIns(0, b, c, $urandom_range(0, 31), 'h00);
      3:  return iIns('h23, a, c, $urandom_range(0, 255));
      4:  return iIns('h0D, a, c, $urandom_range(0, 255));
      5:  return iIns('h04, a, b, $urandom_range(0, 255));
      6:  return rIns(a, 0, 0, 0, 'h08);
      7:  return rIns(a, 0, c, 0, 'h09);
      8:  return rIns(0, 0, c, 0, ($urandom_range(0, 1) == 0) ? 'h10 : 'h12);
      9:  return ($urandom_range(0, 3) == 0) ? rIns(a, b, 0, 0, 'h18 + $urandom_range(0, 3))
                                              : rIns(a, b, c, 0, 'h23);
      10: return iIns('h2B, a, b, $urandom_range(0, 255));
      11: return iIns('h0F, 0, c, $urandom_range(0, 255));
      12: return iIns('h03, 0, 0, 0) | 32'h00000040;
      default: return iIns('h01, a, $urandom_range(0, 1), 4);
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    cyc        = 0;
    busyEnd    = -1;
    stallTotal = 0;
  endtask

  task automatic modelEdge();
    if (expLat > 0) busyEnd = cyc + expLat;
    if (expStall)   stallTotal++;
    cyc++;
  endtask

  task automatic checkOutput(input string tag);
    tbDec_t dD, dE, dM, dW;
    bit busy, useE, useM;
    int satCnt;
    dD   = refDecode(insD);
    dE   = refDecode(insE);
    dM   = refDecode(insM);
    dW   = refDecode(insW);
    busy = (reset == 1'b0) && (cyc <= busyEnd);
    useE = hit(dD.srcA, dE.dst) || hit(dD.srcB, dE.dst);
    useM = hit(dD.srcA, dM.dst) || hit(dD.srcB, dM.dst);
    expStall = (dE.ld && useE) ||
               (dD.br && (useE || (dM.ld && useM))) ||
               (dD.hilo && (busy || dE.lat > 0));
    expLat = dE.lat;
    satCnt = (stallTotal > 15) ? 15 : stallTotal;
    checkVal({tag, ".FAD"},   fAD,      refFwd(dD.srcA, dM, dW));
    checkVal({tag, ".FBD"},   fBD,      refFwd(dD.srcB, dM, dW));
    checkVal({tag, ".FAE"},   fAE,      refFwd(dE.srcA, dM, dW));
    checkVal({tag, ".FBE"},   fBE,      refFwd(dE.srcB, dM, dW));
    checkVal({tag, ".stall"}, stallOut, expStall);
    checkVal({tag, ".busy"},  busyOut,  busy);
    checkVal({tag, ".cnt"},   cntOut,   stallTotal);
    checkVal({tag, ".sStall"}, sStall,  expStall);
    checkVal({tag, ".sBusy"},  sBusy,   busy);
    checkVal({tag, ".sCnt"},   sCnt,    satCnt);
    checkVal({tag, ".sFAE"},   sAE,     refFwd(dE.srcA, dM, dW));
  endtask

  // Advance one clock (updating the model at the edge), then present a new
  // set of stage words at the falling edge and check the settled outputs
  task automatic applyStimulus(input string tag, input logic [31:0] d, input logic [31:0] e,
                               input logic [31:0] m, input logic [31:0] w);
    @(posedge clk);
    if (!reset) modelEdge();
    @(negedge clk);
    insD = d; insE = e; insM = m; insW = w;
    #1;
    checkOutput(tag);
  endtask

  logic [31:0] ADDU3, SUBU4, LW5, ADDU6, BEQ7, ORI7, MFLO8, MULT12, DIV12;
  logic [31:0] ADDU0, ORI0, BEQ00;
  int nStall, nBusy;

  initial begin
    ADDU3  = rIns(1, 2, 3, 0, 'h21);
    SUBU4  = rIns(3, 3, 4, 0, 'h23);
    LW5    = iIns('h23, 0, 5, 0);
    ADDU6  = rIns(5, 0, 6, 0, 'h21);
    BEQ7   = iIns('h04, 7, 0, 3);
    ORI7   = iIns('h0D, 0, 7, 1);
    MFLO8  = rIns(0, 0, 8, 0, 'h12);
    MULT12 = rIns(1, 2, 0, 0, 'h18);
    DIV12  = rIns(1, 2, 0, 0, 'h1A);
    ADDU0  = rIns(1, 2, 0, 0, 'h21);
    ORI0   = iIns('h0D, 0, 0, 5);
    BEQ00  = iIns('h04, 0, 0, 2);

    reset = 1'b1;
    insD = '0; insE = '0; insM = '0; insW = '0;
    @(negedge clk);
    #1;
    checkOutput("rst");
    checkVal("rst.cnt0", cntOut, 0);
    checkVal("rst.busy0", busyOut, 0);

    // Combinational load-use detection is live even while reset is held
    insE = LW5; insD = ADDU6;
    #1;
    checkOutput("rstLu");
    checkVal("rst.luStall", stallOut, 1);
    insE = '0; insD = '0;
    #1;
    checkOutput("rstIdle");
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    // ALU-to-ALU bypass from M, then from W
    applyStimulus("fwdM", 32'h0, SUBU4, ADDU3, 32'h0);
    checkVal("fwdM.AE", fAE, 1);
    checkVal("fwdM.BE", fBE, 1);
    checkVal("fwdM.stall", stallOut, 0);
    applyStimulus("fwdW", 32'h0, SUBU4, 32'h0, ADDU3);
    checkVal("fwdW.AE", fAE, 2);
    checkVal("fwdW.BE", fBE, 2);

    // Load-use: one stall, then bypass from W
    applyStimulus("lu0", ADDU6, LW5, 32'h0, 32'h0);
    checkVal("lu0.stall", stallOut, 1);
    checkVal("lu0.cnt", cntOut, 0);
    applyStimulus("lu1", ADDU6, 32'h0, LW5, 32'h0);
    checkVal("lu1.stall", stallOut, 0);
    checkVal("lu1.cnt", cntOut, 1);
    applyStimulus("lu2", 32'h0, ADDU6, 32'h0, LW5);
    checkVal("lu2.AE", fAE, 2);

    // Branch waits for an ALU producer in E, then bypasses it from M
    applyStimulus("br0", BEQ7, ORI7, 32'h0, 32'h0);
    checkVal("br0.stall", stallOut, 1);
    applyStimulus("br1", BEQ7, 32'h0, ORI7, 32'h0);
    checkVal("br1.stall", stallOut, 0);
    checkVal("br1.AD", fAD, 1);

    // Writes to $0 and the all-zero nop never forward or stall
    applyStimulus("zero0", BEQ00, SUBU4, ADDU0, ORI0);
    checkVal("zero0.AD", fAD, 0);
    checkVal("zero0.AE", fAE, 0);
    checkVal("zero0.stall", stallOut, 0);
    applyStimulus("zero1", rIns(0, 0, 0, 0, 'h21), rIns(0, 0, 0, 0, 'h21), 32'h0, 32'h0);
    checkVal("zero1.BE", fBE, 0);
    checkVal("zero1.stall", stallOut, 0);

    // mflo behind mult: stalls LAT+1 cycles, HI/LO busy LAT cycles
    nStall = 0; nBusy = 0;
    for (int i = 0; i < MULT_LAT + 2; i++) begin
      applyStimulus("mult", MFLO8, (i == 0) ? MULT12 : 32'h0, 32'h0, 32'h0);
      nStall += int'(stallOut);
      nBusy  += int'(busyOut);
    end
    checkVal("mult.stalls", nStall, MULT_LAT + 1);
    checkVal("mult.busy", nBusy, MULT_LAT);

    nStall = 0; nBusy = 0;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      applyStimulus("div", MFLO8, (i == 0) ? DIV12 : 32'h0, 32'h0, 32'h0);
      nStall += int'(stallOut);
      nBusy  += int'(busyOut);
    end
    checkVal("div.stalls", nStall, DIV_LAT + 1);
    checkVal("div.busy", nBusy, DIV_LAT);
    checkVal("sat.cnt32", cntOut, 19);
    checkVal("sat.cnt4", sCnt, 15);

    // Reset in the middle of a divide clears everything immediately
    applyStimulus("mid0", 32'h0, DIV12, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("mid", 32'h0, 32'h0, 32'h0, 32'h0);
    end
    checkVal("mid.busyBefore", busyOut, 1);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("midRst");
    checkVal("midRst.busy", busyOut, 0);
    checkVal("midRst.cnt", cntOut, 0);
    checkVal("midRst.sCnt", sCnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Random stage contents against the model
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rnd", randIns(), randIns(), randIns(), randIns());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
